// File: rtl/fft_cu_pkg.sv
// Shared definitions for the SDF FFT stage control unit.
package fft_cu_pkg;

  localparam int unsigned PIPE_LAT_MAX = 7;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  // Never returns 0, so it is safe as a vector width.
  function automatic int unsigned cu_clog2(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/cu_valid_dly.sv
// 1-bit valid shift register of depth DEPTH with a one-stage-early tap and an empty flag.
module cu_valid_dly #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic out_o,
  output logic pre_o,
  output logic empty_o
);

  logic [DEPTH-1:0] sr_q;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk_i) begin
      if (rst_i) sr_q <= '0;
      else       sr_q <= in_i;
    end
    // With no intermediate stage the early tap is the input itself.
    assign pre_o = in_i;
  end else begin : g_many
    always_ff @(posedge clk_i) begin
      if (rst_i) sr_q <= '0;
      else       sr_q <= {sr_q[DEPTH-2:0], in_i};
    end
    assign pre_o = sr_q[DEPTH-2];
  end

  assign out_o   = sr_q[DEPTH-1];
  assign empty_o = ~|sr_q;

endmodule

// File: rtl/cu_fft_sdf_stage.sv
// Control unit for one radix-2 SDF FFT stage: fill/run/drain sequencing, butterfly and twiddle control.
// Optional output frame_cnt_o is enabled by defining CU_FRAME_CNT_EN.
module cu_fft_sdf_stage
  import fft_cu_pkg::*;
#(
  parameter int unsigned DELAY     = 256,
  parameter int unsigned FRAME_LEN = 512,
  parameter int unsigned PIPE_LAT  = 1,
  parameter int unsigned TW_W      = 9
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            valid_in_i,
  output logic            bf_en_o,
  output logic [TW_W-1:0] tw_idx_o,
  output logic            valid_out_o,
  output logic            alert_next_o,
  output logic            frame_done_o,
`ifdef CU_FRAME_CNT_EN
  output logic [15:0]     frame_cnt_o,
`endif
  output logic            busy_o
);

  localparam int unsigned CW    = cu_clog2(FRAME_LEN);
  localparam int unsigned DLOG  = cu_clog2(DELAY);
  localparam int unsigned TW_SH = $clog2(FRAME_LEN / (2 * DELAY));
  localparam int unsigned DEPTH = PIPE_LAT + 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [DLOG:0]  DELAY_CNT = (DLOG + 1)'(DELAY);

  if (PIPE_LAT > PIPE_LAT_MAX) begin : g_bad_lat
    $error("PIPE_LAT exceeds PIPE_LAT_MAX");
  end

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DLOG:0]   drain_q, drain_d;
  logic [DLOG:0]   fill_after;
  logic            bf_en_q, bf_en_d;
  logic [TW_W-1:0] tw_q, tw_d, tw_new;
  logic            fd_q, fd_d;
  logic            alerted_q, alerted_d;
  logic            accept, sr_in, sr_pre, sr_empty, alert;

  cu_valid_dly #(
    .DEPTH (DEPTH)
  ) u_valid_dly (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_i    (sr_in),
    .out_o   (valid_out_o),
    .pre_o   (sr_pre),
    .empty_o (sr_empty)
  );

  always_comb begin
    accept     = valid_in_i && (state_q == StFill || state_q == StRun);
    // While filling, cnt_q equals the number of samples already in the delay line.
    fill_after = (DLOG + 1)'(cnt_q[DLOG-1:0]) + (DLOG + 1)'(accept);
    tw_new     = cnt_q[DLOG] ? (TW_W'(cnt_q[DLOG-1:0]) << TW_SH) : '0;

    state_d   = state_q;
    cnt_d     = accept ? cnt_q + CW'(1) : cnt_q;
    drain_d   = drain_q;
    alerted_d = alerted_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StFill;
          cnt_d     = '0;
          alerted_d = 1'b0;
        end
      end
      StFill: begin
        if (flush_i) begin
          state_d = StDrain;
          drain_d = fill_after;
        end else if (accept && fill_after == DELAY_CNT) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush_i) begin
          state_d = StDrain;
          drain_d = DELAY_CNT;
        end
      end
      StDrain: begin
        if (drain_q != '0)  drain_d = drain_q - (DLOG + 1)'(1);
        else if (sr_empty)  state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    sr_in = (state_q == StRun && valid_in_i) || (state_q == StDrain && drain_q != '0);
    alert = sr_pre && state_q == StRun && !alerted_q;
    if (alert) alerted_d = 1'b1;

    bf_en_d = accept ? cnt_q[DLOG] : bf_en_q;
    if (state_d == StDrain) bf_en_d = 1'b0;
    tw_d = accept ? tw_new : tw_q;
    fd_d = accept && cnt_q == CNT_LAST && state_d != StDrain;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      drain_q   <= '0;
      bf_en_q   <= 1'b0;
      tw_q      <= '0;
      fd_q      <= 1'b0;
      alerted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      bf_en_q   <= bf_en_d;
      tw_q      <= tw_d;
      fd_q      <= fd_d;
      alerted_q <= alerted_d;
    end
  end

`ifdef CU_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == StIdle && start_i)) frame_cnt_q <= '0;
    else if (fd_d)                               frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

  assign bf_en_o      = bf_en_q;
  assign tw_idx_o     = tw_q;
  assign frame_done_o = fd_q;
  assign alert_next_o = alert;
  assign busy_o       = state_q != StIdle;

endmodule
